// File: rtl/vga_timing_pkg.sv
// Shared VGA raster types and default 640x480@60 timing.
// Axis totals are derived here so the top and the counters agree on geometry.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned MAX_TOTAL = 1024;

    localparam int unsigned CLK_DIV_DEF  = 4;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle: run enable in, pixel coordinates, syncs and pulses out.
interface vga_timing_ctrl_if;
    import vga_timing_pkg::*;

    logic             en;
    logic             pixel_tick;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             line_end;
    logic             frame_end;

    modport master (
        input  en,
        output pixel_tick, h_count, v_count, hsync, vsync, video_on, line_end, frame_end
    );

    modport slave (
        output en,
        input  pixel_tick, h_count, v_count, hsync, vsync, video_on, line_end, frame_end
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Phase is decided from the next count so it always matches the registered count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE_LEN = H_ACTIVE_DEF,
    parameter int unsigned FP         = H_FP_DEF,
    parameter int unsigned SYNC       = H_SYNC_DEF,
    parameter int unsigned BP         = H_BP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_advance,
    output logic [CNT_W-1:0] o_count,
    output phase_e           o_phase,
    output logic             o_wrap
);
    localparam int unsigned      Total      = ACTIVE_LEN + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LastCnt    = CNT_W'(Total - 1);
    localparam logic [CNT_W-1:0] FrontStart = CNT_W'(ACTIVE_LEN);
    localparam logic [CNT_W-1:0] SyncStart  = CNT_W'(ACTIVE_LEN + FP);
    localparam logic [CNT_W-1:0] BackStart  = CNT_W'(ACTIVE_LEN + FP + SYNC);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next_count;
    phase_e           r_phase;
    phase_e           w_next_phase;

    assign o_wrap  = i_advance && (r_count == LastCnt);
    assign o_count = r_count;
    assign o_phase = r_phase;

    always_comb begin
        w_next_count = r_count;
        w_next_phase = r_phase;
        if (i_advance) begin
            w_next_count = o_wrap ? '0 : r_count + CNT_W'(1);
            unique case (r_phase)
                PH_ACTIVE: if (w_next_count == FrontStart) w_next_phase = PH_FRONT;
                PH_FRONT:  if (w_next_count == SyncStart)  w_next_phase = PH_SYNC;
                PH_SYNC:   if (w_next_count == BackStart)  w_next_phase = PH_BACK;
                PH_BACK:   if (o_wrap)                     w_next_phase = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_phase <= PH_ACTIVE;
        end else begin
            r_count <= w_next_count;
            r_phase <= w_next_phase;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-rate divider driving horizontal and vertical axis counters.
// Syncs follow the axis phases, so they naturally hold while en is low.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_ctrl_if.master io_bus
);
    localparam int unsigned     HTotal  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned     VTotal  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_ctrl: CLK_DIV must be at least 1");
    end
    if (HTotal > MAX_TOTAL) begin : g_bad_htotal
        $error("vga_timing_ctrl: H_TOTAL exceeds 10-bit counter range");
    end
    if (VTotal > MAX_TOTAL) begin : g_bad_vtotal
        $error("vga_timing_ctrl: V_TOTAL exceeds 10-bit counter range");
    end

    logic [DivW-1:0] r_div;
    logic            r_en_q;
    logic            w_pixel_tick;
    logic            w_h_wrap;
    logic            w_v_wrap;
    phase_e          w_h_phase;
    phase_e          w_v_phase;

    assign w_pixel_tick = io_bus.en && (r_div == DivLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= io_bus.en;
            if (io_bus.en) begin
                r_div <= w_pixel_tick ? '0 : r_div + DivW'(1);
            end
        end
    end

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP         (H_FP),
        .SYNC       (H_SYNC),
        .BP         (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_pixel_tick),
        .o_count   (io_bus.h_count),
        .o_phase   (w_h_phase),
        .o_wrap    (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP         (V_FP),
        .SYNC       (V_SYNC),
        .BP         (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_h_wrap),
        .o_count   (io_bus.v_count),
        .o_phase   (w_v_phase),
        .o_wrap    (w_v_wrap)
    );

    assign io_bus.pixel_tick = w_pixel_tick;
    assign io_bus.line_end   = w_h_wrap;
    assign io_bus.frame_end  = w_v_wrap;
    assign io_bus.hsync      = (w_h_phase != PH_SYNC);
    assign io_bus.vsync      = (w_v_phase != PH_SYNC);
    assign io_bus.video_on   = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE) && r_en_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: default raster (CLK_DIV=4), CLK_DIV=1 override, and a tiny
// geometry instance small enough to walk a whole frame against a cycle model.
module tb_vga_timing_ctrl;
    import vga_timing_pkg::*;

    logic clk;
    logic rst0;
    logic rst1;
    logic rst2;
    int   n_cmp;
    int   n_err;
    int   cyc;

    vga_timing_ctrl_if bus0 ();
    vga_timing_ctrl_if bus1 ();
    vga_timing_ctrl_if bus2 ();

    vga_timing_ctrl u_dut0 (
        .clk    (clk),
        .reset  (rst0),
        .io_bus (bus0)
    );

    vga_timing_ctrl #(
        .CLK_DIV (1)
    ) u_dut1 (
        .clk    (clk),
        .reset  (rst1),
        .io_bus (bus1)
    );

    // 8/2/3/2 x 6/2/2/3 -> 15 x 13 pixels, 390 clocks per frame at CLK_DIV=2
    vga_timing_ctrl #(
        .CLK_DIV  (2),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) u_dut2 (
        .clk    (clk),
        .reset  (rst2),
        .io_bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        int n_tick;
        int n_hmove;
        int n_le;
        int le_first;
        int le_second;
        int guard;
        int p;
        int eh;
        int ev;
        int e_h, e_v, e_hs, e_vs, e_vid, e_tick, e_le, n_fe, fe_cyc, n_vlow;

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        bus0.en = 1'b1;
        bus1.en = 1'b1;
        bus2.en = 1'b1;
        step();
        step();

        // ---- default geometry, CLK_DIV=4 ----
        rst0 = 1'b0;
        cyc  = 1;
        check_val("rst h_count", int'(bus0.h_count), 0);
        check_val("rst v_count", int'(bus0.v_count), 0);
        check_val("rst hsync", int'(bus0.hsync), 1);
        check_val("rst vsync", int'(bus0.vsync), 1);
        check_val("rst video_on c1", int'(bus0.video_on), 0);
        check_val("rst tick c1", int'(bus0.pixel_tick), 0);
        check_val("rst line_end", int'(bus0.line_end), 0);
        step();
        check_val("video_on c2", int'(bus0.video_on), 1);
        check_val("tick c2", int'(bus0.pixel_tick), 0);
        run_to(4);
        check_val("tick c4", int'(bus0.pixel_tick), 1);
        check_val("h_count c4", int'(bus0.h_count), 0);
        step();
        check_val("h_count c5", int'(bus0.h_count), 1);
        check_val("tick c5", int'(bus0.pixel_tick), 0);

        run_to(2624);
        check_val("h 655", int'(bus0.h_count), 655);
        check_val("hsync at 655", int'(bus0.hsync), 1);
        step();
        check_val("h 656", int'(bus0.h_count), 656);
        check_val("hsync at 656", int'(bus0.hsync), 0);
        check_val("video_on at 656", int'(bus0.video_on), 0);
        run_to(3008);
        check_val("hsync at 751", int'(bus0.hsync), 0);
        step();
        check_val("h 752", int'(bus0.h_count), 752);
        check_val("hsync at 752", int'(bus0.hsync), 1);
        run_to(3199);
        check_val("line_end c3199", int'(bus0.line_end), 0);
        step();
        check_val("line_end c3200", int'(bus0.line_end), 1);
        check_val("h 799", int'(bus0.h_count), 799);
        check_val("frame_end line0", int'(bus0.frame_end), 0);
        step();
        check_val("h wrap", int'(bus0.h_count), 0);
        check_val("v 1", int'(bus0.v_count), 1);
        check_val("line_end after", int'(bus0.line_end), 0);

        // en low for 100 clocks with the divider part-way through a pixel
        run_to(4401);
        check_val("h 300", int'(bus0.h_count), 300);
        step();
        step();
        bus0.en = 1'b0;
        check_val("video_on en fall", int'(bus0.video_on), 1);
        n_tick  = 0;
        n_hmove = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus0.pixel_tick) n_tick++;
            step();
            if (i == 0) check_val("video_on en+1", int'(bus0.video_on), 0);
            if (bus0.h_count != 10'd300) n_hmove++;
        end
        check_val("hold ticks", n_tick, 0);
        check_val("hold h moves", n_hmove, 0);
        check_val("hold hsync", int'(bus0.hsync), 1);
        bus0.en = 1'b1;
        check_val("resume tick c0", int'(bus0.pixel_tick), 0);
        step();
        check_val("resume tick c1", int'(bus0.pixel_tick), 1);
        check_val("resume h c1", int'(bus0.h_count), 300);
        step();
        check_val("resume h 301", int'(bus0.h_count), 301);
        check_val("resume video_on", int'(bus0.video_on), 1);

        // reset in the middle of hsync
        guard = 0;
        while (bus0.h_count != 10'd700 && guard < 5000) begin
            step();
            guard++;
        end
        check_val("reach h 700", int'(bus0.h_count), 700);
        check_val("hsync at 700", int'(bus0.hsync), 0);
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        check_val("mid rst h", int'(bus0.h_count), 0);
        check_val("mid rst v", int'(bus0.v_count), 0);
        check_val("mid rst hsync", int'(bus0.hsync), 1);
        check_val("mid rst vsync", int'(bus0.vsync), 1);
        check_val("mid rst video_on", int'(bus0.video_on), 0);
        check_val("mid rst line_end", int'(bus0.line_end), 0);
        check_val("mid rst tick", int'(bus0.pixel_tick), 0);
        rst0 = 1'b1;

        // ---- CLK_DIV=1 ----
        rst1 = 1'b0;
        n_tick    = 0;
        n_le      = 0;
        le_first  = 0;
        le_second = 0;
        for (int i = 1; i <= 1600; i++) begin
            if (bus1.pixel_tick) n_tick++;
            if (bus1.line_end) begin
                n_le++;
                if (n_le == 1) le_first = i;
                if (n_le == 2) le_second = i;
            end
            step();
        end
        check_val("div1 ticks", n_tick, 1600);
        check_val("div1 line_ends", n_le, 2);
        check_val("div1 first le", le_first, 800);
        check_val("div1 second le", le_second, 1600);
        check_val("div1 v after 2 lines", int'(bus1.v_count), 2);
        rst1 = 1'b1;

        // ---- tiny geometry, full frame against a cycle model ----
        rst2 = 1'b0;
        e_h = 0; e_v = 0; e_hs = 0; e_vs = 0; e_vid = 0; e_tick = 0; e_le = 0;
        n_fe = 0; fe_cyc = 0; n_vlow = 0;
        for (int i = 1; i <= 391; i++) begin
            p  = (i - 1) / 2;
            eh = p % 15;
            ev = (p / 15) % 13;
            if (int'(bus2.h_count) != eh) e_h++;
            if (int'(bus2.v_count) != ev) e_v++;
            if (bus2.hsync != !(eh >= 10 && eh <= 12)) e_hs++;
            if (bus2.vsync != !(ev >= 8 && ev <= 9)) e_vs++;
            if (bus2.video_on != (i >= 2 && eh < 8 && ev < 6)) e_vid++;
            if (bus2.pixel_tick != (i % 2 == 0)) e_tick++;
            if (bus2.line_end != (i % 2 == 0 && eh == 14)) e_le++;
            if (!bus2.vsync) n_vlow++;
            if (bus2.frame_end) begin
                n_fe++;
                fe_cyc = i;
            end
            if (i < 391) step();
        end
        check_val("frame h errs", e_h, 0);
        check_val("frame v errs", e_v, 0);
        check_val("frame hsync errs", e_hs, 0);
        check_val("frame vsync errs", e_vs, 0);
        check_val("frame video_on errs", e_vid, 0);
        check_val("frame tick errs", e_tick, 0);
        check_val("frame line_end errs", e_le, 0);
        check_val("frame vsync low clocks", n_vlow, 60);
        check_val("frame_end count", n_fe, 1);
        check_val("frame_end cycle", fe_cyc, 390);
        check_val("frame wrap h", int'(bus2.h_count), 0);
        check_val("frame wrap v", int'(bus2.v_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
